ex_wb_arb: RTL and testbench

EX_WB_ARB -- requirements
Module: ex_wb_arb

---
 rtl/ex_wb_arb.sv | 163 ++++++++++++++++
 tb/tb_ex_wb_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_wb_arb.sv
// Writeback arbiter: merges ALU results (through a 2-entry holding FIFO) and load
// returns into one registered register-file write port, with a decode hazard check.
`ifndef MAX_BIT_POS
`define MAX_BIT_POS 31
`endif

module ex_wb_arb #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_rd,
    input  logic [`MAX_BIT_POS:0] alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [4:0]            lsu_rd,
    input  logic [`MAX_BIT_POS:0] lsu_data,
    output logic                  lsu_ready,
    output logic                  wb_en,
    output logic [4:0]            wb_rd,
    output logic [`MAX_BIT_POS:0] wb_data,
    input  logic [4:0]            rd_query,
    output logic                  hazard
);

    localparam int unsigned DW   = `MAX_BIT_POS + 1;
    localparam logic [1:0]  FULL = 2'(FIFO_DEPTH);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    logic [4:0]    r_fifo_rd   [2];
    logic [DW-1:0] r_fifo_data [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;
    src_e          r_last_grant;
    logic          r_wb_en;
    logic [4:0]    r_wb_rd;
    logic [DW-1:0] r_wb_data;

    logic          w_fifo_ne;
    logic          w_alu_in_ok;
    logic          w_alu_cand;
    logic          w_lsu_cand;
    logic          w_alu_rdy;
    logic          w_gnt_alu;
    logic          w_gnt_lsu;
    logic          w_pop;
    logic          w_direct;
    logic          w_push;
    logic [4:0]    w_gnt_rd;
    logic [DW-1:0] w_gnt_data;
    logic          w_hz_fifo;
    logic          w_hz_in;
    logic          w_hz_wb;

    // rd=0 offers are accepted but never become candidates, so they are silently dropped.
    assign w_fifo_ne   = (r_count != 2'd0);
    assign w_alu_in_ok = alu_valid && (alu_rd != 5'd0);
    assign w_alu_cand  = w_fifo_ne || w_alu_in_ok;
    assign w_lsu_cand  = lsu_valid && (lsu_rd != 5'd0);
    assign w_alu_rdy   = rst && (r_count != FULL);

    always_comb begin
        w_gnt_alu = 1'b0;
        w_gnt_lsu = 1'b0;
        if (w_alu_cand && w_lsu_cand) begin
            if (r_last_grant == SRC_LSU) begin
                w_gnt_alu = 1'b1;
            end else begin
                w_gnt_lsu = 1'b1;
            end
        end else if (w_alu_cand) begin
            w_gnt_alu = 1'b1;
        end else if (w_lsu_cand) begin
            w_gnt_lsu = 1'b1;
        end
    end

    // A direct ALU grant is only possible with an empty FIFO, which keeps results in order.
    assign w_pop    = w_gnt_alu && w_fifo_ne;
    assign w_direct = w_gnt_alu && !w_fifo_ne;
    assign w_push   = w_alu_rdy && w_alu_in_ok && !w_direct;

    always_comb begin
        w_gnt_rd   = '0;
        w_gnt_data = '0;
        if (w_pop) begin
            w_gnt_rd   = r_fifo_rd[r_rd_ptr];
            w_gnt_data = r_fifo_data[r_rd_ptr];
        end else if (w_direct) begin
            w_gnt_rd   = alu_rd;
            w_gnt_data = alu_data;
        end else if (w_gnt_lsu) begin
            w_gnt_rd   = lsu_rd;
            w_gnt_data = lsu_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_fifo_rd[i]   <= '0;
                r_fifo_data[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_rd[r_wr_ptr]   <= alu_rd;
                r_fifo_data[r_wr_ptr] <= alu_data;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= SRC_LSU;
            r_wb_en      <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
        end else begin
            r_wb_en <= w_gnt_alu || w_gnt_lsu;
            if (w_gnt_alu) begin
                r_last_grant <= SRC_ALU;
            end else if (w_gnt_lsu) begin
                r_last_grant <= SRC_LSU;
            end
            if (w_gnt_alu || w_gnt_lsu) begin
                r_wb_rd   <= w_gnt_rd;
                r_wb_data <= w_gnt_data;
            end
        end
    end

    assign w_hz_fifo = (w_fifo_ne && (r_fifo_rd[r_rd_ptr] == rd_query))
                    || ((r_count == 2'd2) && (r_fifo_rd[~r_rd_ptr] == rd_query));
    assign w_hz_in   = (alu_valid && (alu_rd == rd_query))
                    || (lsu_valid && (lsu_rd == rd_query));
    assign w_hz_wb   = r_wb_en && (r_wb_rd == rd_query);

    assign alu_ready = w_alu_rdy;
    assign lsu_ready = rst && lsu_valid && ((lsu_rd == 5'd0) || w_gnt_lsu);
    assign hazard    = rst && (rd_query != 5'd0) && (w_hz_fifo || w_hz_in || w_hz_wb);
    assign wb_en     = r_wb_en;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;

endmodule

// File: tb/tb_ex_wb_arb.sv
// Directed bench for ex_wb_arb: expected writes go into a scoreboard queue that a
// monitor drains whenever wb_en is seen; handshake and hazard outputs are checked inline.
`ifndef MAX_BIT_POS
`define MAX_BIT_POS 31
`endif

module tb_ex_wb_arb;

    localparam int DW = `MAX_BIT_POS + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alu_valid = 1'b0;
    logic [4:0]    alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          alu_ready;
    logic          lsu_valid = 1'b0;
    logic [4:0]    lsu_rd = '0;
    logic [DW-1:0] lsu_data = '0;
    logic          lsu_ready;
    logic          wb_en;
    logic [4:0]    wb_rd;
    logic [DW-1:0] wb_data;
    logic [4:0]    rd_query = '0;
    logic          hazard;

    typedef struct {
        logic [4:0]    rd;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    ex_wb_arb #(.FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .lsu_valid (lsu_valid),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .lsu_ready (lsu_ready),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .rd_query  (rd_query),
        .hazard    (hazard)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Grant on the coming edge shows up as wb_en in the cycle after it.
    task automatic expect_wr(input logic [4:0] rd, input logic [DW-1:0] d);
        wr_t e;
        e.rd   = rd;
        e.data = d;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [DW-1:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [DW-1:0] ld);
        @(negedge clk);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        lsu_valid = lv;
        lsu_rd    = lrd;
        lsu_data  = ld;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    always @(posedge clk) begin
        #1;
        if (wb_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected: got write rd=%0d data=%0h at cycle %0d, expected no write",
                         wb_rd, wb_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_rd", DW'(wb_rd), DW'(mon_e.rd));
                chk("wb_data", wb_data, mon_e.data);
                chk("wb_cycle", DW'(cyc), DW'(mon_e.cyc));
            end
        end
    end

    initial begin
        #2 rst = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 'h22;
        rd_query  = 5'd5;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_wb_en", DW'(wb_en), 0);
        chk("rst_wb_rd", DW'(wb_rd), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_alu_ready", DW'(alu_ready), 0);
        chk("rst_lsu_ready", DW'(lsu_ready), 0);
        chk("rst_hazard", DW'(hazard), 0);
        @(negedge clk);
        rst = 1'b1;
        alu_valid = 1'b0; lsu_valid = 1'b0; rd_query = 5'd0;

        // Tie after reset: ALU first, then LSU.
        drive(1'b1, 5'd3, 'hAA, 1'b1, 5'd4, 'hBB);
        chk("tie_alu_ready", DW'(alu_ready), 1);
        chk("tie_lsu_ready0", DW'(lsu_ready), 0);
        expect_wr(5'd3, 'hAA);
        drive(1'b0, 5'd0, '0, 1'b1, 5'd4, 'hBB);
        chk("tie_lsu_ready1", DW'(lsu_ready), 1);
        expect_wr(5'd4, 'hBB);
        idle();
        chk("tie_lsu_ready_idle", DW'(lsu_ready), 0);

        // rd=0 offers dropped; last grant stays LSU so ALU wins the next tie.
        drive(1'b1, 5'd0, 'hFF, 1'b1, 5'd0, 'hEE);
        chk("rd0_alu_ready", DW'(alu_ready), 1);
        chk("rd0_lsu_ready", DW'(lsu_ready), 1);
        idle();
        drive(1'b1, 5'd5, 'h55, 1'b1, 5'd6, 'h66);
        chk("rd0_tie_lsu_ready", DW'(lsu_ready), 0);
        expect_wr(5'd5, 'h55);
        drive(1'b0, 5'd0, '0, 1'b1, 5'd6, 'h66);
        chk("rd0_tie_lsu_ready1", DW'(lsu_ready), 1);
        expect_wr(5'd6, 'h66);

        // ALU only.
        drive(1'b1, 5'd5, 'h11, 1'b0, 5'd0, '0);
        chk("alu_only_ready", DW'(alu_ready), 1);
        expect_wr(5'd5, 'h11);
        idle();
        chk("alu_only_ready_idle", DW'(alu_ready), 1);

        // FIFO fill with LSU contending; last grant is ALU here.
        drive(1'b1, 5'd11, 'hB1, 1'b1, 5'd20, 'hC0);
        chk("fill0_lsu_ready", DW'(lsu_ready), 1);
        chk("fill0_alu_ready", DW'(alu_ready), 1);
        expect_wr(5'd20, 'hC0);
        drive(1'b1, 5'd12, 'hB2, 1'b1, 5'd21, 'hC1);
        chk("fill1_lsu_ready", DW'(lsu_ready), 0);
        chk("fill1_alu_ready", DW'(alu_ready), 1);
        expect_wr(5'd11, 'hB1);
        drive(1'b1, 5'd13, 'hB3, 1'b1, 5'd21, 'hC1);
        chk("fill2_lsu_ready", DW'(lsu_ready), 1);
        chk("fill2_alu_ready", DW'(alu_ready), 1);
        expect_wr(5'd21, 'hC1);
        drive(1'b1, 5'd14, 'hB4, 1'b1, 5'd22, 'hC2);
        chk("fill3_alu_ready_full", DW'(alu_ready), 0);
        chk("fill3_lsu_ready", DW'(lsu_ready), 0);
        expect_wr(5'd12, 'hB2);
        drive(1'b1, 5'd14, 'hB4, 1'b1, 5'd22, 'hC2);
        chk("fill4_alu_ready", DW'(alu_ready), 1);
        chk("fill4_lsu_ready", DW'(lsu_ready), 1);
        expect_wr(5'd22, 'hC2);
        idle();
        chk("fill5_alu_ready_full", DW'(alu_ready), 0);
        expect_wr(5'd13, 'hB3);
        idle();
        chk("fill6_alu_ready", DW'(alu_ready), 1);
        expect_wr(5'd14, 'hB4);
        idle();
        chk("fill7_alu_ready", DW'(alu_ready), 1);

        // Hazard tracking for rd7 through input, FIFO and pending write.
        rd_query = 5'd7;
        drive(1'b1, 5'd7, 'h71, 1'b1, 5'd30, 'h30);
        chk("hz0", DW'(hazard), 1);
        chk("hz0_lsu_ready", DW'(lsu_ready), 1);
        expect_wr(5'd30, 'h30);
        drive(1'b1, 5'd7, 'h72, 1'b1, 5'd31, 'h31);
        chk("hz1", DW'(hazard), 1);
        chk("hz1_lsu_ready", DW'(lsu_ready), 0);
        expect_wr(5'd7, 'h71);
        drive(1'b0, 5'd0, '0, 1'b1, 5'd31, 'h31);
        chk("hz2", DW'(hazard), 1);
        chk("hz2_lsu_ready", DW'(lsu_ready), 1);
        expect_wr(5'd31, 'h31);
        idle();
        chk("hz3_fifo", DW'(hazard), 1);
        expect_wr(5'd7, 'h72);
        idle();
        chk("hz4_wb_pending", DW'(hazard), 1);
        idle();
        chk("hz5_retired", DW'(hazard), 0);
        rd_query = 5'd0;
        drive(1'b1, 5'd0, 'h1, 1'b1, 5'd0, 'h2);
        chk("hz_query0", DW'(hazard), 0);
        rd_query = 5'd9;
        drive(1'b0, 5'd0, '0, 1'b1, 5'd9, 'h99);
        chk("hz_lsu_in", DW'(hazard), 1);
        chk("hz_lsu_ready", DW'(lsu_ready), 1);
        expect_wr(5'd9, 'h99);
        rd_query = 5'd0;

        // Reset mid-operation with FIFO full and LSU pending; last grant is LSU.
        drive(1'b1, 5'd16, 'h16, 1'b1, 5'd17, 'h17);
        chk("r0_lsu_ready", DW'(lsu_ready), 0);
        expect_wr(5'd16, 'h16);
        drive(1'b1, 5'd18, 'h18, 1'b1, 5'd17, 'h17);
        chk("r1_lsu_ready", DW'(lsu_ready), 1);
        expect_wr(5'd17, 'h17);
        drive(1'b1, 5'd23, 'h23, 1'b1, 5'd19, 'h19);
        chk("r2_lsu_ready", DW'(lsu_ready), 0);
        expect_wr(5'd18, 'h18);
        drive(1'b1, 5'd24, 'h24, 1'b1, 5'd19, 'h19);
        chk("r3_lsu_ready", DW'(lsu_ready), 1);
        expect_wr(5'd19, 'h19);
        rd_query = 5'd26;
        drive(1'b1, 5'd25, 'h25, 1'b1, 5'd26, 'h26);
        chk("r4_alu_ready_full", DW'(alu_ready), 0);
        chk("r4_lsu_ready", DW'(lsu_ready), 0);
        chk("r4_hazard", DW'(hazard), 1);
        chk("r4_wb_en", DW'(wb_en), 1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_wb_en", DW'(wb_en), 0);
        chk("midrst_wb_rd", DW'(wb_rd), 0);
        chk("midrst_wb_data", wb_data, 0);
        chk("midrst_alu_ready", DW'(alu_ready), 0);
        chk("midrst_lsu_ready", DW'(lsu_ready), 0);
        chk("midrst_hazard", DW'(hazard), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        rd_query  = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd27; alu_data = 'h27;
        lsu_valid = 1'b1; lsu_rd = 5'd28; lsu_data = 'h28;
        #1;
        chk("post_rst_alu_ready", DW'(alu_ready), 1);
        chk("post_rst_lsu_ready", DW'(lsu_ready), 0);
        expect_wr(5'd27, 'h27);
        drive(1'b0, 5'd0, '0, 1'b1, 5'd28, 'h28);
        chk("post_rst_lsu_ready1", DW'(lsu_ready), 1);
        expect_wr(5'd28, 'h28);
        repeat (3) idle();
        chk("scoreboard_empty", DW'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
